cg_prev_vector_bank: RTL and testbench

- Parametrised, multi-channel, double-buffered store for "previous-iteration" CG vectors (r, x, p, A·p partials).
- Supersedes per-vector prev memories with a single block.
- Each channel has two banks: the current bank receives writes during an iteration; the previous bank serves reads.
- A swap at end of iteration exchanges the bank roles per channel, under a mask.

---
 rtl/cg_prev_vector_bank.sv | 85 ++++++++
 tb/tb_cg_prev_vector_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cg_prev_vector_bank.sv
// cg_prev_vector_bank: per-channel double-buffered store for previous-iteration CG vectors.
// Writes fill the current bank, reads serve the previous bank, and a masked swap exchanges the two.
module cg_prev_vector_bank #(
    parameter int element_width      = 32,
    parameter int no_of_units        = 8,
    parameter int number_of_channels = 4,
    parameter int ch_sel_width       = 2,
    parameter int depth              = 128,
    parameter int addr_width         = 7
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [ch_sel_width-1:0]                wr_channel,
    input  logic                                   wr_auto,
    input  logic [addr_width-1:0]                  wr_addr,
    input  logic [element_width*no_of_units-1:0]   wr_data,
    input  logic                                   rd_en,
    input  logic [ch_sel_width-1:0]                rd_channel,
    input  logic [addr_width-1:0]                  rd_addr,
    output logic [element_width*no_of_units-1:0]   rd_data,
    output logic                                   rd_valid,
    output logic                                   rd_oob,
    input  logic                                   swap,
    input  logic [number_of_channels-1:0]          swap_mask,
    output logic [15:0]                            iteration_count,
    output logic [number_of_channels-1:0]          overflow
);
    localparam int dw = element_width * no_of_units;
    localparam logic [addr_width:0] one = 1;
    logic [dw-1:0] mem [number_of_channels][2][depth];
    logic [number_of_channels-1:0] bank_sel;
    logic [addr_width:0] wr_count [number_of_channels];
    logic [addr_width:0] wr_count_nxt [number_of_channels];
    logic [addr_width:0] prev_count [number_of_channels];
    logic [addr_width:0] wr_res, wr_end;
    logic wr_ch_ok, rd_ch_ok, wr_hit, rd_out;
    assign wr_ch_ok = int'(wr_channel) < number_of_channels;
    assign rd_ch_ok = int'(rd_channel) < number_of_channels;
    assign wr_res   = wr_auto ? wr_count[wr_channel] : {1'b0, wr_addr};
    assign wr_end   = {1'b0, wr_addr} + one;
    assign wr_hit   = wr_en && wr_ch_ok && int'(wr_res) < depth;
    assign rd_out   = !rd_ch_ok || {1'b0, rd_addr} >= prev_count[rd_channel];
    // next fill level including this cycle's write, so a same-cycle swap captures it
    always_comb begin
        for (int c = 0; c < number_of_channels; c++)
            wr_count_nxt[c] = !(wr_hit && int'(wr_channel) == c) ? wr_count[c] :
                              wr_auto ? wr_count[c] + one :
                              wr_end > wr_count[c] ? wr_end : wr_count[c];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel        <= '0;
            for (int c = 0; c < number_of_channels; c++) begin
                wr_count[c]   <= '0;
                prev_count[c] <= '0;
            end
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            rd_oob          <= 1'b0;
            iteration_count <= '0;
            overflow        <= '0;
        end else begin
            for (int c = 0; c < number_of_channels; c++) begin
                wr_count[c] <= swap && swap_mask[c] ? '0 : wr_count_nxt[c];
                if (swap && swap_mask[c]) begin
                    prev_count[c] <= wr_count_nxt[c];
                    bank_sel[c]   <= !bank_sel[c];
                end
            end
            if (wr_en && wr_ch_ok && !wr_hit)
                overflow[wr_channel] <= 1'b1;
            if (swap && |swap_mask && iteration_count != 16'hFFFF)
                iteration_count <= iteration_count + 16'd1;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_oob  <= rd_out;
                rd_data <= rd_out ? '0 : mem[rd_channel][!bank_sel[rd_channel]][rd_addr];
            end
        end
    end
    always_ff @(posedge clk)
        if (!reset && wr_hit)
            mem[wr_channel][bank_sel[wr_channel]][wr_res[addr_width-1:0]] <= wr_data;
endmodule

// File: tb/tb_cg_prev_vector_bank.sv
// tb_cg_prev_vector_bank: directed plus random checks of cg_prev_vector_bank against an
// array-swapping reference model (current/previous vectors per channel).
module tb_cg_prev_vector_bank;
    localparam int dw = 256;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, wr_en, wr_auto, rd_en, swap, rd_valid, rd_oob;
    logic [1:0] wr_channel, rd_channel;
    logic [6:0] wr_addr, rd_addr;
    logic [dw-1:0] wr_data, rd_data;
    logic [3:0] swap_mask, overflow;
    logic [15:0] iteration_count;
    int tests = 0, fails = 0;

    cg_prev_vector_bank dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_channel(wr_channel), .wr_auto(wr_auto),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_channel(rd_channel),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_oob(rd_oob),
        .swap(swap), .swap_mask(swap_mask), .iteration_count(iteration_count), .overflow(overflow)
    );

    logic [dw-1:0] cur [4][128];
    logic [dw-1:0] prv [4][128];
    bit cur_k [4][128];
    bit prv_k [4][128];
    int wcnt [4];
    int pcnt [4];
    int m_iter;
    logic [3:0] m_ovf;
    logic [dw-1:0] e_data;
    logic e_oob, e_valid;
    bit e_known;

    function automatic logic [dw-1:0] word(input logic [31:0] b);
        return {8{b}};
    endfunction

    task automatic chk(input string tag, input logic [dw-1:0] obs, input logic [dw-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; wr_auto = 0; wr_channel = 0; wr_addr = 0; wr_data = '0;
        rd_en = 0; rd_channel = 0; rd_addr = 0; swap = 0; swap_mask = 0;
    endtask

    // advance the model by one clock using the driven inputs, then clock the DUT and compare
    task automatic tick();
        int a;
        logic [dw-1:0] t;
        bit tk;
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                wcnt[c] = 0; pcnt[c] = 0;
                for (int i = 0; i < 128; i++) begin cur_k[c][i] = 0; prv_k[c][i] = 0; end
            end
            m_iter = 0; m_ovf = 0; e_data = '0; e_oob = 0; e_valid = 0; e_known = 1;
        end else begin
            e_valid = rd_en;
            if (rd_en) begin
                e_oob   = int'(rd_addr) >= pcnt[rd_channel];
                e_data  = e_oob ? '0 : prv[rd_channel][rd_addr];
                e_known = e_oob || prv_k[rd_channel][rd_addr];
            end
            if (wr_en) begin
                a = wr_auto ? wcnt[wr_channel] : int'(wr_addr);
                if (a >= 128) m_ovf[wr_channel] = 1'b1;
                else begin
                    cur[wr_channel][a] = wr_data;
                    cur_k[wr_channel][a] = 1;
                    wcnt[wr_channel] = wr_auto ? wcnt[wr_channel] + 1 :
                        (a + 1 > wcnt[wr_channel] ? a + 1 : wcnt[wr_channel]);
                end
            end
            if (swap) begin
                for (int c = 0; c < 4; c++) if (swap_mask[c]) begin
                    for (int i = 0; i < 128; i++) begin
                        t = cur[c][i]; cur[c][i] = prv[c][i]; prv[c][i] = t;
                        tk = cur_k[c][i]; cur_k[c][i] = prv_k[c][i]; prv_k[c][i] = tk;
                    end
                    pcnt[c] = wcnt[c];
                    wcnt[c] = 0;
                end
                if (swap_mask != 0 && m_iter < 65535) m_iter++;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid, e_valid);
        chk("rd_oob", rd_oob, e_oob);
        if (e_known) chk("rd_data", rd_data, e_data);
        chk("iteration_count", iteration_count, m_iter);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic rst();
        idle(); reset = 1; tick();
    endtask
    task automatic wr(input int ch, input bit au, input int ad, input logic [dw-1:0] d);
        idle(); wr_en = 1; wr_channel = 2'(ch); wr_auto = au; wr_addr = 7'(ad); wr_data = d; tick();
    endtask
    task automatic rd(input int ch, input int ad);
        idle(); rd_en = 1; rd_channel = 2'(ch); rd_addr = 7'(ad); tick();
    endtask
    task automatic sw(input logic [3:0] m);
        idle(); swap = 1; swap_mask = m; tick();
    endtask

    initial begin
        idle();
        rst();
        chk("reset_iter", iteration_count, 16'd0);
        // basic fill, swap, read back with one past the end
        for (int i = 0; i < 5; i++) wr(0, 1, 0, word(32'hA0 + 32'(i)));
        sw(4'b0001);
        for (int a = 0; a < 6; a++) begin
            rd(0, a);
            if (a < 5) chk("t1_data", rd_data, word(32'hA0 + 32'(a)));
        end
        chk("t1_oob5", rd_oob, 1'b1);
        chk("t1_zero5", rd_data, '0);
        chk("t1_iter", iteration_count, 16'd1);
        // overflow on the depth+1'th write
        for (int i = 0; i < 129; i++) wr(2, 1, 0, word(32'(i)));
        chk("t2_ovf", overflow, 4'b0100);
        sw(4'b0100);
        rd(2, 127);
        chk("t2_data127", rd_data, word(32'd127));
        chk("t2_oob127", rd_oob, 1'b0);
        chk("t2_ovf_sticky", overflow, 4'b0100);
        // write in the swap cycle lands in the new previous bank
        wr(1, 1, 0, word(32'hC0));
        wr(1, 1, 0, word(32'hC1));
        idle(); wr_en = 1; wr_channel = 1; wr_auto = 1; wr_data = word(32'hC2);
        swap = 1; swap_mask = 4'b0010; tick();
        rd(1, 2);
        chk("t3_data2", rd_data, word(32'hC2));
        rd(1, 3);
        chk("t3_oob3", rd_oob, 1'b1);
        // masked swap leaves other channels alone
        rst();
        for (int i = 0; i < 4; i++) begin
            wr(0, 1, 0, word(32'hD0 + 32'(i)));
            wr(3, 1, 0, word(32'hE0 + 32'(i)));
        end
        sw(4'b1000);
        rd(0, 0);
        chk("t4_ch0_oob", rd_oob, 1'b1);
        for (int a = 0; a < 4; a++) begin
            rd(3, a);
            chk("t4_ch3_data", rd_data, word(32'hE0 + 32'(a)));
        end
        idle(); wr_en = 1; wr_channel = 3; wr_auto = 1; wr_data = word(32'hF0);
        rd_en = 1; rd_channel = 3; rd_addr = 1; tick();
        chk("t4_old_data", rd_data, word(32'hE1));
        // explicit addressing sets fill level to highest address + 1
        wr(1, 0, 10, word(32'hB10));
        wr(1, 0, 4, word(32'hB04));
        sw(4'b0010);
        rd(1, 10);
        chk("t5_data10", rd_data, word(32'hB10));
        rd(1, 4);
        chk("t5_data4", rd_data, word(32'hB04));
        rd(1, 11);
        chk("t5_oob11", rd_oob, 1'b1);
        // reset while a read is in flight
        wr(2, 0, 127, word(32'h1));
        wr(2, 1, 0, word(32'h2));
        rd(3, 0);
        idle(); reset = 1; rd_en = 1; tick();
        chk("t6_valid", rd_valid, 1'b0);
        chk("t6_iter", iteration_count, 16'd0);
        chk("t6_ovf", overflow, 4'd0);
        rd(0, 0);
        chk("t6_oob", rd_oob, 1'b1);
        // random traffic
        rst();
        repeat (800) begin
            idle();
            wr_en = 1'($urandom);
            wr_channel = 2'($urandom);
            wr_auto = ($urandom % 4) != 0;
            wr_addr = 7'($urandom % 20);
            for (int l = 0; l < 8; l++) wr_data[l*32 +: 32] = $urandom;
            rd_en = 1'($urandom);
            rd_channel = 2'($urandom);
            rd_addr = 7'($urandom % 20);
            swap = ($urandom % 8) == 0;
            swap_mask = 4'($urandom);
            reset = ($urandom % 200) == 0;
            tick();
        end
        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
